operand_stage: RTL and testbench
================================

OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 Parameter DATA_W SHALL default to 64 and set the operand width.
REQ-003 Parameter ZERO_REG SHALL default to 31 and give the hardwired-zero register index.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock, posedge active
- reset  in  1  async active-high reset
- id_valid  in  1  IF/ID holds a real instruction
- id_Rn, id_Rm, id_Rd  in  5  source and destination register numbers
- id_rd1, id_rd2  in  DATA_W  register-file read data for Rn and Rm
- id_ctrl  in  8  decoded control; bit0 = RegWrite, bit1 = MemRead
- ex_Rd, mem_Rd, wb_Rd  in  5  destinations in EX, MEM and WB
- ex_RegWrite, mem_RegWrite, wb_RegWrite  in  1  write enables per stage
- ex_result, mem_result, wb_result  in  DATA_W  values per stage
- flush  in  1  branch-taken kill of the ID instruction
- stall  out  1  hold PC and IF/ID
- q_valid  out  1  registered ID/EX valid
- q_A, q_B  out  DATA_W  registered forwarded operands
- q_Rd  out  5  registered destination
- q_ctrl  out  8  registered control

Function
REQ-005 Operand selection for Rn (A) and Rm (B) SHALL be combinational, using this priority:
- ZERO_REG source: 0
- EX match: ex_result
- MEM match: mem_result
- WB match: wb_result
- otherwise: id_rd*
REQ-006 A stage "matches" a source only if that stage's RegWrite = 1, its Rd equals the source, and its Rd is not ZERO_REG.
REQ-007 WB forwarding SHALL exist because register-file writes become visible only after the WB clock edge.
REQ-008 A load-use hazard exists when all of the following hold: id_valid = 1, q_valid = 1, q_ctrl[1] = 1, q_Rd is not ZERO_REG, and q_Rd equals id_Rn or id_Rm.
REQ-009 The state machine SHALL have two states, RUN and LU_STALL.
- RUN to LU_STALL on a load-use hazard with flush = 0.
- LU_STALL to RUN unconditionally after one cycle.
REQ-010 In RUN with a hazard, stall SHALL be 1 combinationally that cycle, and the next edge SHALL load q_valid = 0 (bubble) with q_ctrl = 0.
REQ-011 In LU_STALL, stall SHALL be 0, and the held instruction SHALL load normally with the load value forwarded from MEM.
REQ-012 Without a hazard or flush, each edge SHALL load q_* from the selected operands and id_*, with q_valid = id_valid; latency from ID to q_* is one cycle.
REQ-013 flush SHALL take priority over everything:
- stall = 0
- next q_valid = 0 and q_ctrl = 0
- next state = RUN, including when flush arrives during LU_STALL
REQ-014 When q_valid = 0, q_ctrl SHALL always be 0, so a bubble never writes or reads memory.
REQ-015 Simultaneous EX, MEM and WB matches SHALL resolve to EX; A and B SHALL resolve independently.
REQ-016 id_valid = 0 SHALL never raise stall.

Reset
REQ-017 While reset = 1, the block SHALL hold: state = RUN; q_valid, q_A, q_B, q_Rd, q_ctrl = 0; stall = 0.
REQ-018 Reset asserted mid-stall SHALL abort the stall immediately, and the first edge after release SHALL behave as in RUN.

Structure
REQ-019 Package pipe_pkg SHALL hold DATA_W, ZERO_REG, the control-bit indices (CTRL_REGWRITE = 0, CTRL_MEMREAD = 1) and the state enum {RUN, LU_STALL}.
REQ-020 Sub-module fwd_sel SHALL implement the REQ-005 priority select for one operand and SHALL be instanced twice, for A and B.
REQ-021 Pipeline registers SHALL use per-bit D_FF with the reset port driven, matching the existing register style.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- EX forward: id_Rn = 3, ex_Rd = 3, ex_RegWrite = 1, ex_result = 0xAA, id_rd1 = 0x11 -> next q_A = 0xAA, stall = 0.
- Priority: Rm = 5 matches EX (0x1), MEM (0x2) and WB (0x3) -> q_B = 0x1; with EX RegWrite = 0 -> q_B = 0x2.
- Zero register: id_Rn = 31, ex_Rd = 31, ex_RegWrite = 1, ex_result = 0xFF -> q_A = 0.
- Load-use: q holds a load with q_Rd = 7; id_Rm = 7 -> stall = 1 for one cycle, one bubble (q_valid = 0, q_ctrl = 0); next cycle q_B = mem_result = 0x1234.
- Flush during LU_STALL -> q_valid = 0, state = RUN, stall = 0.
- Reset asserted during stall -> all outputs 0 asynchronously; after release a normal instruction passes with one-cycle latency.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and types for the ID/EX operand stage.
package pipe_pkg;

    localparam int DATA_W        = 64;
    localparam int ZERO_REG      = 31;
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } state_e;

endpackage

// File: rtl/D_FF.sv
// Single-bit pipeline flop with asynchronous active-high clear.
module D_FF (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/fwd_sel.sv
// Priority operand select for one source register: zero reg, EX, MEM, WB, then register file.
module fwd_sel #(
    parameter int DATA_W   = pipe_pkg::DATA_W,
    parameter int ZERO_REG = pipe_pkg::ZERO_REG
) (
    input  logic [4:0]        src,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_we,
    input  logic [DATA_W-1:0] ex_val,
    input  logic [4:0]        mem_rd,
    input  logic              mem_we,
    input  logic [DATA_W-1:0] mem_val,
    input  logic [4:0]        wb_rd,
    input  logic              wb_we,
    input  logic [DATA_W-1:0] wb_val,
    output logic [DATA_W-1:0] data
);

    logic src_is_zero;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // A stage writing the zero register never counts as a producer.
    assign src_is_zero = (src == 5'(ZERO_REG));
    assign ex_hit      = ex_we  && (ex_rd  == src) && (ex_rd  != 5'(ZERO_REG));
    assign mem_hit     = mem_we && (mem_rd == src) && (mem_rd != 5'(ZERO_REG));
    assign wb_hit      = wb_we  && (wb_rd  == src) && (wb_rd  != 5'(ZERO_REG));

    always_comb begin
        data = rf_data;
        if (src_is_zero) begin
            data = '0;
        end else if (ex_hit) begin
            data = ex_val;
        end else if (mem_hit) begin
            data = mem_val;
        end else if (wb_hit) begin
            data = wb_val;
        end
    end

endmodule

// File: rtl/operand_stage.sv
// ID/EX operand stage: forwarding select, load-use stall FSM and the ID/EX pipeline register.
module operand_stage #(
    parameter int DATA_W   = pipe_pkg::DATA_W,
    parameter int ZERO_REG = pipe_pkg::ZERO_REG
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [4:0]           id_Rn,
    input  logic [4:0]           id_Rm,
    input  logic [4:0]           id_Rd,
    input  logic [DATA_W-1:0]    id_rd1,
    input  logic [DATA_W-1:0]    id_rd2,
    input  logic [7:0]           id_ctrl,
    input  logic [4:0]           ex_Rd,
    input  logic [4:0]           mem_Rd,
    input  logic [4:0]           wb_Rd,
    input  logic                 ex_RegWrite,
    input  logic                 mem_RegWrite,
    input  logic                 wb_RegWrite,
    input  logic [DATA_W-1:0]    ex_result,
    input  logic [DATA_W-1:0]    mem_result,
    input  logic [DATA_W-1:0]    wb_result,
    input  logic                 flush,
    output logic                 stall,
    output logic                 q_valid,
    output logic [DATA_W-1:0]    q_A,
    output logic [DATA_W-1:0]    q_B,
    output logic [4:0]           q_Rd,
    output logic [7:0]           q_ctrl,
    output pipe_pkg::state_e     dbg_state
);

    import pipe_pkg::*;

    localparam int REG_W = 2 * DATA_W + 14;

    state_e            state_q;
    state_e            state_d;
    logic              hazard;
    logic              bubble;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic              valid_d;
    logic [7:0]        ctrl_d;
    logic [4:0]        rd_d;
    logic [DATA_W-1:0] a_d;
    logic [DATA_W-1:0] b_d;
    logic [REG_W-1:0]  pipe_d;
    logic [REG_W-1:0]  pipe_q;

    fwd_sel #(.DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) u_fwd_a (
        .src     (id_Rn),
        .rf_data (id_rd1),
        .ex_rd   (ex_Rd),
        .ex_we   (ex_RegWrite),
        .ex_val  (ex_result),
        .mem_rd  (mem_Rd),
        .mem_we  (mem_RegWrite),
        .mem_val (mem_result),
        .wb_rd   (wb_Rd),
        .wb_we   (wb_RegWrite),
        .wb_val  (wb_result),
        .data    (fwd_a)
    );

    fwd_sel #(.DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) u_fwd_b (
        .src     (id_Rm),
        .rf_data (id_rd2),
        .ex_rd   (ex_Rd),
        .ex_we   (ex_RegWrite),
        .ex_val  (ex_result),
        .mem_rd  (mem_Rd),
        .mem_we  (mem_RegWrite),
        .mem_val (mem_result),
        .wb_rd   (wb_Rd),
        .wb_we   (wb_RegWrite),
        .wb_val  (wb_result),
        .data    (fwd_b)
    );

    // The instruction now in EX is a load whose result the ID instruction needs.
    assign hazard = id_valid && q_valid && q_ctrl[CTRL_MEMREAD]
                 && (q_Rd != 5'(ZERO_REG))
                 && ((q_Rd == id_Rn) || (q_Rd == id_Rm));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (flush) begin
                    bubble = 1'b1;
                end else if (hazard) begin
                    stall   = 1'b1;
                    bubble  = 1'b1;
                    state_d = LU_STALL;
                end
            end
            LU_STALL: begin
                state_d = RUN;
                bubble  = flush;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Bubbles carry zero control so they can never write or touch memory.
    assign valid_d = bubble ? 1'b0 : id_valid;
    assign ctrl_d  = (bubble || !id_valid) ? 8'h00 : id_ctrl;
    assign rd_d    = bubble ? 5'd0 : id_Rd;
    assign a_d     = bubble ? '0 : fwd_a;
    assign b_d     = bubble ? '0 : fwd_b;
    assign pipe_d  = {valid_d, ctrl_d, rd_d, b_d, a_d};

    for (genvar i = 0; i < REG_W; i++) begin : g_pipe
        D_FF u_ff (
            .clk   (clk),
            .reset (reset),
            .d     (pipe_d[i]),
            .q     (pipe_q[i])
        );
    end

    assign {q_valid, q_ctrl, q_Rd, q_B, q_A} = pipe_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed vector table, load-use/flush/reset sequences, random vs model.
module tb_operand_stage;

  localparam int W = 64;

  logic         clk;
  logic         reset;
  logic         id_valid;
  logic [4:0]   id_Rn, id_Rm, id_Rd;
  logic [W-1:0] id_rd1, id_rd2;
  logic [7:0]   id_ctrl;
  logic [4:0]   ex_Rd, mem_Rd, wb_Rd;
  logic         ex_RegWrite, mem_RegWrite, wb_RegWrite;
  logic [W-1:0] ex_result, mem_result, wb_result;
  logic         flush;
  logic         stall;
  logic         q_valid;
  logic [W-1:0] q_A, q_B;
  logic [4:0]   q_Rd;
  logic [7:0]   q_ctrl;
  pipe_pkg::state_e dbg_state;

  int n_pass;
  int n_total;

  operand_stage dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_Rn        (id_Rn),
    .id_Rm        (id_Rm),
    .id_Rd        (id_Rd),
    .id_rd1       (id_rd1),
    .id_rd2       (id_rd2),
    .id_ctrl      (id_ctrl),
    .ex_Rd        (ex_Rd),
    .mem_Rd       (mem_Rd),
    .wb_Rd        (wb_Rd),
    .ex_RegWrite  (ex_RegWrite),
    .mem_RegWrite (mem_RegWrite),
    .wb_RegWrite  (wb_RegWrite),
    .ex_result    (ex_result),
    .mem_result   (mem_result),
    .wb_result    (wb_result),
    .flush        (flush),
    .stall        (stall),
    .q_valid      (q_valid),
    .q_A          (q_A),
    .q_B          (q_B),
    .q_Rd         (q_Rd),
    .q_ctrl       (q_ctrl),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [4:0]   rn, rm, rd;
    logic [W-1:0] rd1, rd2;
    logic [7:0]   ctrl;
    logic [4:0]   exr, memr, wbr;
    logic         exw, memw, wbw;
    logic [W-1:0] exv, memv, wbv;
    logic [W-1:0] ea, eb;
    logic         ev;
    logic [7:0]   ec;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_Rn = 0; id_Rm = 0; id_Rd = 0; id_rd1 = 0; id_rd2 = 0; id_ctrl = 0;
    ex_Rd = 0; mem_Rd = 0; wb_Rd = 0;
    ex_RegWrite = 0; mem_RegWrite = 0; wb_RegWrite = 0;
    ex_result = 0; mem_result = 0; wb_result = 0;
    flush = 0;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                          input logic [4:0] rd, input logic [W-1:0] rd1,
                          input logic [W-1:0] rd2, input logic [7:0] ctrl);
    id_valid = v; id_Rn = rn; id_Rm = rm; id_Rd = rd;
    id_rd1 = rd1; id_rd2 = rd2; id_ctrl = ctrl;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Puts a load to r7 into ID/EX, then presents a consumer of r7 via Rm.
  task automatic setup_load_use();
    idle_inputs();
    drive_id(1, 5'd0, 5'd0, 5'd7, 64'h0, 64'h0, 8'h03);
    tick();
    drive_id(1, 5'd1, 5'd7, 5'd10, 64'h10, 64'hDEAD, 8'h01);
    #1;
  endtask

  // Reference model: forwarding priority written straight from the rules.
  function automatic logic [W-1:0] ref_fwd(input logic [4:0] src, input logic [W-1:0] rf);
    if (src == 5'd31) return '0;
    if (ex_RegWrite && ex_Rd == src && ex_Rd != 5'd31) return ex_result;
    if (mem_RegWrite && mem_Rd == src && mem_Rd != 5'd31) return mem_result;
    if (wb_RegWrite && wb_Rd == src && wb_Rd != 5'd31) return wb_result;
    return rf;
  endfunction

  function automatic logic [4:0] rand_reg();
    if ($urandom_range(0, 7) == 0) return 5'd31;
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    n_pass = 0;
    n_total = 0;
    idle_inputs();
    reset = 1'b1;
    #2;
    chk("reset_q_valid", {63'd0, q_valid}, 64'd0);
    chk("reset_q_A", q_A, 64'd0);
    chk("reset_q_B", q_B, 64'd0);
    chk("reset_q_Rd", {59'd0, q_Rd}, 64'd0);
    chk("reset_q_ctrl", {56'd0, q_ctrl}, 64'd0);
    chk("reset_stall", {63'd0, stall}, 64'd0);
    chk("reset_state", {63'd0, dbg_state}, 64'd0);
    tick();
    reset = 1'b0;

    // v rn rm rd rd1 rd2 ctrl | exr memr wbr | exw memw wbw | exv memv wbv | ea eb ev ec
    tbl[0] = '{1'b1, 5'd3, 5'd4, 5'd9, 64'h11, 64'h22, 8'h01, 5'd3, 5'd0, 5'd0,
               1'b1, 1'b0, 1'b0, 64'hAA, 64'h0, 64'h0, 64'hAA, 64'h22, 1'b1, 8'h01};
    tbl[1] = '{1'b1, 5'd1, 5'd5, 5'd2, 64'h10, 64'h20, 8'h01, 5'd5, 5'd5, 5'd5,
               1'b1, 1'b1, 1'b1, 64'h1, 64'h2, 64'h3, 64'h10, 64'h1, 1'b1, 8'h01};
    tbl[2] = '{1'b1, 5'd1, 5'd5, 5'd2, 64'h10, 64'h20, 8'h01, 5'd5, 5'd5, 5'd5,
               1'b0, 1'b1, 1'b1, 64'h1, 64'h2, 64'h3, 64'h10, 64'h2, 1'b1, 8'h01};
    tbl[3] = '{1'b1, 5'd31, 5'd4, 5'd3, 64'h77, 64'h44, 8'h05, 5'd31, 5'd0, 5'd0,
               1'b1, 1'b0, 1'b0, 64'hFF, 64'h0, 64'h0, 64'h0, 64'h44, 1'b1, 8'h05};
    tbl[4] = '{1'b1, 5'd6, 5'd6, 5'd1, 64'h1, 64'h2, 8'h01, 5'd6, 5'd7, 5'd6,
               1'b0, 1'b1, 1'b1, 64'h8, 64'h99, 64'h5555, 64'h5555, 64'h5555, 1'b1, 8'h01};
    tbl[5] = '{1'b1, 5'd8, 5'd9, 5'd4, 64'h1, 64'h2, 8'hF1, 5'd9, 5'd8, 5'd8,
               1'b1, 1'b1, 1'b1, 64'hE, 64'hD, 64'hC, 64'hD, 64'hE, 1'b1, 8'hF1};
    tbl[6] = '{1'b0, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 8'hFF, 5'd0, 5'd0, 5'd0,
               1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 8'h00};
    tbl[7] = '{1'b1, 5'd12, 5'd13, 5'd14, 64'hCAFE, 64'hBEEF, 8'h01, 5'd12, 5'd13, 5'd31,
               1'b0, 1'b0, 1'b1, 64'h1, 64'h2, 64'h3, 64'hCAFE, 64'hBEEF, 1'b1, 8'h01};

    for (int i = 0; i < 8; i++) begin
      drive_id(tbl[i].v, tbl[i].rn, tbl[i].rm, tbl[i].rd, tbl[i].rd1, tbl[i].rd2, tbl[i].ctrl);
      ex_Rd = tbl[i].exr; mem_Rd = tbl[i].memr; wb_Rd = tbl[i].wbr;
      ex_RegWrite = tbl[i].exw; mem_RegWrite = tbl[i].memw; wb_RegWrite = tbl[i].wbw;
      ex_result = tbl[i].exv; mem_result = tbl[i].memv; wb_result = tbl[i].wbv;
      flush = 1'b0;
      #1;
      chk($sformatf("vec%0d_stall", i), {63'd0, stall}, 64'd0);
      tick();
      chk($sformatf("vec%0d_q_valid", i), {63'd0, q_valid}, {63'd0, tbl[i].ev});
      chk($sformatf("vec%0d_q_ctrl", i), {56'd0, q_ctrl}, {56'd0, tbl[i].ec});
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_q_A", i), q_A, tbl[i].ea);
        chk($sformatf("vec%0d_q_B", i), q_B, tbl[i].eb);
        chk($sformatf("vec%0d_q_Rd", i), {59'd0, q_Rd}, {59'd0, tbl[i].rd});
      end
    end

    // load-use: one stall cycle, one bubble, then MEM forwards the load value
    setup_load_use();
    chk("lu_stall_high", {63'd0, stall}, 64'd1);
    tick();
    chk("lu_bubble_valid", {63'd0, q_valid}, 64'd0);
    chk("lu_bubble_ctrl", {56'd0, q_ctrl}, 64'd0);
    chk("lu_state_stall", {63'd0, dbg_state}, 64'd1);
    mem_Rd = 5'd7; mem_RegWrite = 1'b1; mem_result = 64'h1234;
    #1;
    chk("lu_stall_released", {63'd0, stall}, 64'd0);
    tick();
    chk("lu_q_valid", {63'd0, q_valid}, 64'd1);
    chk("lu_q_B", q_B, 64'h1234);
    chk("lu_q_A", q_A, 64'h10);
    chk("lu_state_run", {63'd0, dbg_state}, 64'd0);

    // flush while in LU_STALL
    setup_load_use();
    tick();
    flush = 1'b1;
    mem_Rd = 5'd7; mem_RegWrite = 1'b1; mem_result = 64'h1234;
    #1;
    chk("fl_stall", {63'd0, stall}, 64'd0);
    tick();
    chk("fl_q_valid", {63'd0, q_valid}, 64'd0);
    chk("fl_q_ctrl", {56'd0, q_ctrl}, 64'd0);
    chk("fl_state", {63'd0, dbg_state}, 64'd0);
    flush = 1'b0;

    // reset while stall is asserted in RUN
    setup_load_use();
    reset = 1'b1;
    #1;
    chk("rs_q_valid", {63'd0, q_valid}, 64'd0);
    chk("rs_q_Rd", {59'd0, q_Rd}, 64'd0);
    chk("rs_q_ctrl", {56'd0, q_ctrl}, 64'd0);
    chk("rs_stall", {63'd0, stall}, 64'd0);
    tick();

    // reset while in LU_STALL, then a normal instruction after release
    reset = 1'b0;
    setup_load_use();
    tick();
    reset = 1'b1;
    #1;
    chk("rs2_state", {63'd0, dbg_state}, 64'd0);
    chk("rs2_q_A", q_A, 64'd0);
    tick();
    reset = 1'b0;
    idle_inputs();
    drive_id(1, 5'd3, 5'd4, 5'd9, 64'h11, 64'h22, 8'h01);
    ex_Rd = 5'd3; ex_RegWrite = 1'b1; ex_result = 64'hAA;
    #1;
    chk("rs2_no_stall", {63'd0, stall}, 64'd0);
    chk("rs2_latency", {63'd0, q_valid}, 64'd0);
    tick();
    chk("rs2_q_valid", {63'd0, q_valid}, 64'd1);
    chk("rs2_q_A", q_A, 64'hAA);
    chk("rs2_q_B", q_B, 64'h22);

    // randomized run against the reference model
    idle_inputs();
    do_reset();
    begin
      logic         m_stall, m_valid, hz, e_stall, bub;
      logic [7:0]   m_ctrl;
      logic [4:0]   m_rd;
      logic [W-1:0] m_a, m_b;
      m_stall = 0; m_valid = 0; m_ctrl = 0; m_rd = 0; m_a = 0; m_b = 0;
      for (int c = 0; c < 400; c++) begin
        id_valid = ($urandom_range(0, 7) != 0);
        id_Rn = rand_reg(); id_Rm = rand_reg(); id_Rd = rand_reg();
        id_rd1 = {$urandom, $urandom}; id_rd2 = {$urandom, $urandom};
        id_ctrl = 8'($urandom);
        ex_Rd = rand_reg(); mem_Rd = rand_reg(); wb_Rd = rand_reg();
        ex_RegWrite = 1'($urandom); mem_RegWrite = 1'($urandom); wb_RegWrite = 1'($urandom);
        ex_result = {$urandom, $urandom};
        mem_result = {$urandom, $urandom};
        wb_result = {$urandom, $urandom};
        flush = ($urandom_range(0, 9) == 0);
        #1;
        hz = id_valid && m_valid && m_ctrl[1] && (m_rd != 5'd31)
          && ((m_rd == id_Rn) || (m_rd == id_Rm));
        e_stall = !flush && !m_stall && hz;
        chk($sformatf("rnd%0d_stall", c), {63'd0, stall}, {63'd0, e_stall});
        bub = flush || e_stall;
        if (bub) begin
          m_valid = 0; m_ctrl = 0;
        end else begin
          m_valid = id_valid;
          m_ctrl = id_valid ? id_ctrl : 8'h00;
          m_rd = id_Rd;
          m_a = ref_fwd(id_Rn, id_rd1);
          m_b = ref_fwd(id_Rm, id_rd2);
        end
        m_stall = e_stall;
        tick();
        chk($sformatf("rnd%0d_q_valid", c), {63'd0, q_valid}, {63'd0, m_valid});
        chk($sformatf("rnd%0d_q_ctrl", c), {56'd0, q_ctrl}, {56'd0, m_ctrl});
        chk($sformatf("rnd%0d_state", c), {63'd0, dbg_state}, {63'd0, m_stall});
        if (m_valid) begin
          chk($sformatf("rnd%0d_q_A", c), q_A, m_a);
          chk($sformatf("rnd%0d_q_B", c), q_B, m_b);
          chk($sformatf("rnd%0d_q_Rd", c), {59'd0, q_Rd}, {59'd0, m_rd});
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
